// File: rtl/mips_data_mem.sv
// mips_data_mem: data/instruction memory responder for the multicycle MIPS core.
// Big-endian byte-addressed RAM with a small MMIO window (LED, cycle counter,
// status). Reads are registered, so data appears one cycle after the address.
//
// Ports:
//   clk           clock, all state on the rising edge
//   reset         asynchronous, active-high
//   MemWrite      1 = store this cycle, 0 = read
//   MemMode       00 word, 01 halfword, 10 byte, 11 word
//   writeMemData  store data, right-justified for half/byte
//   memAddr       byte address
//   memData       registered read data, right-justified, zero-extended
//   led_out       LED register contents
//   misalign_err  sticky misaligned-access flag
//   err_addr      address of the first misaligned access since the last clear
module mips_data_mem #(
  parameter int          MEM_WORDS = 16384,
  parameter string       INIT_FILE = "",
  parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [1:0]  MemMode,
  input  logic [31:0] writeMemData,
  input  logic [15:0] memAddr,
  output logic [31:0] memData,
  output logic [31:0] led_out,
  output logic        misalign_err,
  output logic [15:0] err_addr
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // MMIO register word addresses (memAddr[15:2])
  localparam logic [13:0] LED_WADDR    = 14'h3FFC;  // 0xFFF0
  localparam logic [13:0] CYCLE_WADDR  = 14'h3FFD;  // 0xFFF4
  localparam logic [13:0] STATUS_WADDR = 14'h3FFE;  // 0xFFF8

  logic [31:0] ram [MEM_WORDS];

  logic [31:0] ledReg;
  logic [31:0] cycleCnt;
  logic        misalignErr;
  logic [15:0] errAddr;

  logic             isWord, isHalf, isByte;
  logic             misaligned, isMmio;
  logic             hitLed, hitCycle, hitStatus;
  logic [IDX_W-1:0] wordIdx;
  logic [3:0]       laneEn;
  logic [31:0]      laneData;
  logic [31:0]      srcWord;
  logic [31:0]      readFmt;
  logic             ramWe, ledWe, statusClr;

  // Lane i covers bits [8i+7:8i]; lane 3 is byte offset 0 (big-endian).
  function automatic logic [31:0] mergeLanes(input logic [31:0] oldW,
                                             input logic [31:0] newW,
                                             input logic [3:0]  en);
    logic [31:0] res;
    res = oldW;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) res[8*i +: 8] = newW[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    isWord     = (MemMode == 2'b00) || (MemMode == 2'b11);
    isHalf     = (MemMode == 2'b01);
    isByte     = (MemMode == 2'b10);
    misaligned = (isWord && (memAddr[1:0] != 2'b00)) || (isHalf && memAddr[0]);
    isMmio     = (memAddr >= MMIO_BASE);
    hitLed     = isMmio && (memAddr[15:2] == LED_WADDR);
    hitCycle   = isMmio && (memAddr[15:2] == CYCLE_WADDR);
    hitStatus  = isMmio && (memAddr[15:2] == STATUS_WADDR);
    wordIdx    = IDX_W'(32'(memAddr[15:2]) % 32'(MEM_WORDS));

    laneEn   = 4'b1111;
    laneData = writeMemData;
    if (isHalf) begin
      laneEn   = memAddr[1] ? 4'b0011 : 4'b1100;
      laneData = {2{writeMemData[15:0]}};
    end else if (isByte) begin
      laneEn   = 4'b1000 >> memAddr[1:0];
      laneData = {4{writeMemData[7:0]}};
    end

    srcWord = 32'h0;
    if (!isMmio)        srcWord = ram[wordIdx];
    else if (hitLed)    srcWord = ledReg;
    else if (hitCycle)  srcWord = cycleCnt;
    else if (hitStatus) srcWord = {31'h0, misalignErr};

    readFmt = srcWord;
    if (isHalf)      readFmt = {16'h0, 16'(srcWord >> {~memAddr[1], 4'b0000})};
    else if (isByte) readFmt = {24'h0, 8'(srcWord >> {~memAddr[1:0], 3'b000})};

    // reset gates the RAM port so a store caught by reset is never performed
    ramWe     = MemWrite && !misaligned && !isMmio && !reset;
    ledWe     = MemWrite && !misaligned && hitLed;
    statusClr = MemWrite && !misaligned && hitStatus && isWord && writeMemData[0];
  end

  always_ff @(posedge clk) begin
    if (ramWe) ram[wordIdx] <= mergeLanes(ram[wordIdx], laneData, laneEn);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memData     <= 32'h0;
      ledReg      <= 32'h0;
      cycleCnt    <= 32'h0;
      misalignErr <= 1'b0;
      errAddr     <= 16'h0;
    end else begin
      memData  <= misaligned ? 32'h0 : readFmt;
      cycleCnt <= cycleCnt + 32'd1;
      if (ledWe) ledReg <= mergeLanes(ledReg, laneData, laneEn);
      // a new misalign event takes priority over a clear on the same edge
      if (misaligned) begin
        misalignErr <= 1'b1;
        if (!misalignErr) errAddr <= memAddr;
      end else if (statusClr) begin
        misalignErr <= 1'b0;
        errAddr     <= 16'h0;
      end
    end
  end

  assign led_out      = ledReg;
  assign misalign_err = misalignErr;
  assign err_addr     = errAddr;

endmodule
